// File: rtl/cnt_pwm_gen.sv
// PWM generator slaved to an upstream free-running W-bit up counter.
// Latency: outputs reflect the cnt_in sample from the previous rising edge.
// Backpressure: duty_ready low while a duty waits in the pending slot for the next wrap.
module cnt_pwm_gen #(
  parameter int W   = 4,
  parameter int PCW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   cnt_in,
  input  logic [W:0]     duty_in,
  input  logic           duty_valid,
  output logic           duty_ready,
  output logic           pwm_out,
  output logic           wrap_tick,
  output logic [PCW-1:0] period_cnt,
  output logic           seq_err
);

  localparam logic [W:0]   DUTY_MAX = (W + 1)'(1) << W;
  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};

  logic [W-1:0] prev_cnt;
  logic         prev_vld;
  logic [W:0]   pend_duty;
  logic         pend_full;
  logic [W:0]   act_duty;

  logic [W:0]   duty_sat;
  logic         is_adv;
  logic         is_stall;
  logic         is_wrap;
  logic         apply_pend;
  logic         xfer;
  logic [W:0]   eff_duty;

  always_comb begin
    duty_sat   = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
    is_adv     = prev_vld && (cnt_in == prev_cnt + 1'b1);
    is_stall   = prev_vld && (cnt_in == prev_cnt);
    is_wrap    = is_adv && (prev_cnt == CNT_MAX);
    apply_pend = is_wrap && pend_full;
    xfer       = duty_valid && !pend_full;
    // A wrap that swaps in the pending duty must already use it for this sample.
    eff_duty   = apply_pend ? pend_duty : act_duty;
  end

  assign duty_ready = ~pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cnt   <= '0;
      prev_vld   <= 1'b0;
      pend_duty  <= '0;
      pend_full  <= 1'b0;
      act_duty   <= '0;
      pwm_out    <= 1'b0;
      wrap_tick  <= 1'b0;
      period_cnt <= '0;
      seq_err    <= 1'b0;
    end else begin
      prev_cnt  <= cnt_in;
      prev_vld  <= 1'b1;
      pwm_out   <= ({1'b0, cnt_in} < eff_duty);
      wrap_tick <= is_wrap;
      if (is_wrap)
        period_cnt <= period_cnt + 1'b1;
      if (prev_vld && !is_adv && !is_stall)
        seq_err <= 1'b1;
      // A transfer needs an empty slot and an apply needs a full one, so they never collide.
      if (apply_pend) begin
        act_duty  <= pend_duty;
        pend_full <= 1'b0;
      end
      if (xfer) begin
        pend_duty <= duty_sat;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnt_pwm_gen.sv
// Bench for cnt_pwm_gen: drives an emulated upstream counter and compares against a period-level model.
module tb_cnt_pwm_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cnt_in = '0;
  logic [4:0] duty_in = '0;
  logic       duty_valid = 1'b0;
  logic       duty_ready;
  logic       pwm_out;
  logic       wrap_tick;
  logic [7:0] period_cnt;
  logic       seq_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_prev, m_vld, m_act, m_period, m_err, e_pwm, e_tick;
  int m_pend[$];
  int ucnt;

  cnt_pwm_gen #(.W(4), .PCW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .duty_in(duty_in),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .pwm_out(pwm_out),
    .wrap_tick(wrap_tick), .period_cnt(period_cnt), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  wire [11:0] obs = {pwm_out, wrap_tick, duty_ready, seq_err, period_cnt};

  function automatic logic [11:0] expv();
    logic rdy;
    rdy = (m_pend.size() == 0);
    return {e_pwm[0], e_tick[0], rdy, m_err[0], m_period[7:0]};
  endfunction

  task automatic model_reset();
    m_vld = 0; m_prev = 0; m_act = 0; m_period = 0; m_err = 0;
    e_pwm = 0; e_tick = 0;
    m_pend.delete();
  endtask

  // Drive one sample, advance the model, and return #1 after the rising edge.
  task automatic step(input int c, input bit dv, input int d);
    bit wrap;
    bit slot_empty;
    int eff;
    @(negedge clk);
    cnt_in = c[3:0];
    duty_valid = dv;
    duty_in = d[4:0];
    slot_empty = (m_pend.size() == 0);
    wrap = 0;
    if (m_vld != 0) begin
      if (c == (m_prev + 1) % 16) wrap = (m_prev == 15);
      else if (c != m_prev) m_err = 1;
    end
    eff = m_act;
    if (wrap && m_pend.size() > 0) begin
      eff = m_pend.pop_front();
      m_act = eff;
    end
    e_pwm = (c < eff) ? 1 : 0;
    if (dv && slot_empty) m_pend.push_back((d > 16) ? 16 : d);
    e_tick = wrap ? 1 : 0;
    if (wrap) m_period = (m_period + 1) % 256;
    m_prev = c;
    m_vld = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input bit dv, input int d);
    step(ucnt, dv, d);
    ucnt = (ucnt + 1) % 16;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== expv()) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, expv());
    end
    rst_n = 1'b1;
    ucnt = 0;
  endtask

  task automatic test_free_run();
    for (int k = 0; k < 49; k++) begin
      adv(0, 0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL free_run step %0d: got %h expected %h", k, obs, expv());
      end
    end
    checks++;
    if (period_cnt !== 8'd3) begin
      errors++;
      $display("FAIL free_run_periods: got %0d expected 3", period_cnt);
    end
  endtask

  task automatic test_duty5();
    int highs;
    while (ucnt != 7) begin
      adv(0, 0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL duty5_pre: got %h expected %h", obs, expv());
      end
    end
    adv(1, 5);
    checks++;
    if (duty_ready !== 1'b0) begin
      errors++;
      $display("FAIL duty5_ready_drop: got %b expected 0", duty_ready);
    end
    while (ucnt != 0) begin
      adv(0, 0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL duty5_wait: got %h expected %h", obs, expv());
      end
    end
    highs = 0;
    for (int k = 0; k < 16; k++) begin
      adv(0, 0);
      highs += pwm_out;
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL duty5_period step %0d: got %h expected %h", k, obs, expv());
      end
    end
    checks++;
    if (highs != 5) begin
      errors++;
      $display("FAIL duty5_high_count: got %0d expected 5", highs);
    end
  endtask

  task automatic test_duty_values();
    int dv_list[3] = '{0, 16, 31};
    int highs;
    for (int i = 0; i < 3; i++) begin
      while (ucnt != 3) begin
        adv(0, 0);
        checks++;
        if (obs !== expv()) begin
          errors++;
          $display("FAIL duty_val_pre %0d: got %h expected %h", dv_list[i], obs, expv());
        end
      end
      adv(1, dv_list[i]);
      while (ucnt != 0) begin
        adv(0, 0);
        checks++;
        if (obs !== expv()) begin
          errors++;
          $display("FAIL duty_val_wait %0d: got %h expected %h", dv_list[i], obs, expv());
        end
      end
      for (int p = 0; p < 2; p++) begin
        highs = 0;
        for (int k = 0; k < 16; k++) begin
          adv(0, 0);
          highs += pwm_out;
          checks++;
          if (obs !== expv()) begin
            errors++;
            $display("FAIL duty_val_run %0d: got %h expected %h", dv_list[i], obs, expv());
          end
        end
        checks++;
        if (highs != ((dv_list[i] > 16) ? 16 : dv_list[i])) begin
          errors++;
          $display("FAIL duty_val_highs %0d: got %0d expected %0d", dv_list[i], highs,
                   (dv_list[i] > 16) ? 16 : dv_list[i]);
        end
      end
    end
  endtask

  task automatic test_wrap_offer();
    int highs;
    while (ucnt != 0) begin
      adv(0, 0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL wrap_offer_pre: got %h expected %h", obs, expv());
      end
    end
    for (int p = 0; p < 2; p++) begin
      highs = 0;
      for (int k = 0; k < 16; k++) begin
        adv((p == 0 && k == 0), 8);
        highs += pwm_out;
        checks++;
        if (obs !== expv()) begin
          errors++;
          $display("FAIL wrap_offer_run p%0d k%0d: got %h expected %h", p, k, obs, expv());
        end
      end
      checks++;
      if (highs != ((p == 0) ? 16 : 8)) begin
        errors++;
        $display("FAIL wrap_offer_highs p%0d: got %0d expected %0d", p, highs, (p == 0) ? 16 : 8);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] p_before;
    while (ucnt != 1) begin
      adv(0, 0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL stall_pre: got %h expected %h", obs, expv());
      end
    end
    p_before = period_cnt;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0);
      checks++;
      if (obs !== expv() || wrap_tick !== 1'b0 || period_cnt !== p_before || seq_err !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold %0d: got %h expected %h period_before %0d", k, obs, expv(), p_before);
      end
    end
    for (int k = 0; k < 5; k++) begin
      adv(0, 0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL stall_release %0d: got %h expected %h", k, obs, expv());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) step(ucnt, ($urandom_range(0, 2) == 0), $urandom_range(0, 31));
      else adv(($urandom_range(0, 2) == 0), $urandom_range(0, 31));
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL random step %0d: got %h expected %h", k, obs, expv());
      end
    end
  endtask

  task automatic test_seq_err();
    while (ucnt != 3) adv(0, 0);
    adv(1, 7);
    step(9, 0, 0);
    ucnt = 10;
    checks++;
    if (seq_err !== 1'b1 || obs !== expv()) begin
      errors++;
      $display("FAIL seq_err_set: got %h expected %h", obs, expv());
    end
    for (int k = 0; k < 4; k++) begin
      adv(0, 0);
      checks++;
      if (seq_err !== 1'b1 || obs !== expv()) begin
        errors++;
        $display("FAIL seq_err_sticky %0d: got %h expected %h", k, obs, expv());
      end
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== expv() || seq_err !== 1'b0 || duty_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_clear: got %h expected %h", obs, expv());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ucnt = 5;
    for (int k = 0; k < 20; k++) begin
      adv(0, 0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL post_reset %0d: got %h expected %h", k, obs, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_duty5();
    test_duty_values();
    test_wrap_offer();
    test_stall();
    test_random();
    test_seq_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_pwm_gen.md
# cnt_pwm_gen

Downstream consumer of the 4-bit free-running up counter's count output.
- Turns the count into a registered PWM waveform whose duty is loaded through a valid/ready handshake and applied only at count wrap-around, so no period is ever glitched.
- Also reports wrap ticks, counts completed periods, and flags a sticky error if the incoming count does not follow the +1 sequence.

## Interface
Parameters:
- W, 4: width of the incoming count; period is 2^W clocks.
- PCW, 8: width of the completed-period counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cnt_in  in  W  count from the upstream up counter.
- duty_in  in  W+1  requested high-time in clocks, 0..2^W; values above 2^W saturate to 2^W.
- duty_valid  in  1  duty_in is offered.
- duty_ready  out  1  pending-duty slot is empty; a transfer occurs when duty_valid and duty_ready are both 1 on a rising edge.
- pwm_out  out  1  registered PWM output.
- wrap_tick  out  1  one-cycle pulse, registered, for each detected wrap from 2^W-1 to 0.
- period_cnt  out  PCW  number of wraps seen since reset, modulo 2^PCW.
- seq_err  out  1  sticky sequence-error flag.

## Operation
Internal state:
- prev_cnt (W) and prev_vld (1): last sample of cnt_in, and whether it is valid.
- pend_duty (W+1) and pend_full (1): the pending-duty slot.
- act_duty (W+1): the duty currently applied.

Reset (rst_n=0, asynchronous):
- All outputs and internal registers go to 0, except duty_ready.
- duty_ready = 1, because the pending slot is empty.
- act_duty = 0, so pwm_out stays low until a duty is applied.

Sample classification, on every clock with rst_n=1:
- First cycle after reset (prev_vld=0): cnt_in is captured, prev_vld is set, and no classification is made.
- Advance: cnt_in == prev_cnt+1 modulo 2^W.
- Wrap: an advance where prev_cnt == 2^W-1 and cnt_in == 0.
- Stall: cnt_in == prev_cnt. This covers the upstream counter being held in its reset at 0. It is not an error and produces no wrap.
- Any other value: set seq_err. It stays set until rst_n is asserted.
- prev_cnt <= cnt_in every cycle.

Duty handshake:
- duty_ready = ~pend_full.
- On a transfer: pend_duty <= saturated duty_in and pend_full <= 1.
- On a wrap with pend_full=1: act_duty <= pend_duty and pend_full <= 0, so duty_ready returns high on the next cycle.
- Transfer and wrap in the same cycle (pend_full was 0): the new value goes to the pending slot and takes effect at the following wrap.

PWM compare:
- The compare uses the duty effective for this sample. On a wrap cycle that applies a pending duty, this is pend_duty; otherwise it is act_duty.
- pwm_out <= (cnt_in < effective duty).
- duty 0 gives a constant low output; duty 2^W gives a constant high output.

Period counter:
- period_cnt increments by 1 on each wrap, rolling from 2^PCW-1 to 0.
- wrap_tick is asserted for the cycle after the wrap sample.

## Timing
- Latency: pwm_out, wrap_tick, period_cnt and seq_err all reflect the cnt_in sampled on the previous rising edge (1 cycle).
- Duty change: effective from the wrap sample at the first wrap strictly after the transfer edge. The first affected pwm_out edge is one cycle after that wrap sample.
- duty_ready is low from the cycle after a transfer until the cycle after the applying wrap.
- rst_n asserted mid-period:
  - Outputs clear immediately, with no clock needed.
  - The pending duty is discarded.
  - After release, the first sample only seeds prev_cnt.
- The first cycle after rst_n release performs no compare side effects beyond pwm_out = (cnt_in < 0), which is 0.

## Test plan
- Reset, then counter free-running from 0, no duty loaded -> pwm_out=0 throughout; wrap_tick pulses every 16 clocks; period_cnt = 3 after 48+1 clocks; seq_err=0; duty_ready=1.
- Load duty 5 mid-period at cnt=7 -> duty_ready drops the next cycle; pwm_out stays 0 until the wrap; then high for cnt 0..4 (5 clocks) and low for 11 clocks; duty_ready returns to 1 one cycle after the wrap.
- Duty 0, 16 and 31 -> constant low; constant high; constant high (31 saturated to 16).
- Duty offered on the exact wrap cycle with the slot empty (value 8) -> the current period keeps the old duty; 8 applies from the next wrap.
- Hold the counter in its reset for 10 clocks mid-run (cnt_in=0 repeated), then release -> no seq_err; no extra wrap_tick; period_cnt unchanged during the stall.
- Force cnt_in to jump 3->9, then assert rst_n=0 for 1 clock -> seq_err=1 one cycle after the jump and stays set; it clears asynchronously on reset, and period_cnt, pwm_out and duty_ready return to their reset values.
